// File: rtl/i2c_pkg.sv
// Shared types and constants for the oversampled I2C slave register file.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
    } i2c_state_t;

    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;
    localparam logic [6:0] I2C_SLAVE_ADDR = 7'h53;

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Pad-side and fabric-side signals of the I2C slave register file.
interface i2c_slave_regfile_if #(
    parameter int PTR_W = 4
);
    logic             scl_i;
    logic             sda_i;
    logic             sda_oe;
    logic             host_wr_en;
    logic [PTR_W-1:0] host_addr;
    logic [7:0]       host_wdata;
    logic             rx_valid;
    logic [PTR_W-1:0] rx_addr;
    logic [7:0]       rx_data;
    logic             busy;

    modport slave (
        input  scl_i, sda_i, host_wr_en, host_addr, host_wdata,
        output sda_oe, rx_valid, rx_addr, rx_data, busy
    );

    modport master (
        output scl_i, sda_i, host_wr_en, host_addr, host_wdata,
        input  sda_oe, rx_valid, rx_addr, rx_data, busy
    );
endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser + glitch filter for one pad line; emits registered level and edge pulses.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic [CNT_W-1:0]       cnt;
    logic                   samp;

    assign samp = sync_q[SYNC_STAGES-1];

    // Until the synchroniser holds real pad samples, the level tracks it silently so
    // a reset taken mid-transfer cannot fabricate a START or STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            vld_pipe <= '0;
            level    <= 1'b1;
            cnt      <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            rise     <= 1'b0;
            fall     <= 1'b0;
            if (!vld_pipe[SYNC_STAGES]) begin
                level <= samp;
                cnt   <= '0;
            end else if (samp == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                level <= samp;
                cnt   <= '0;
                rise  <= samp;
                fall  <= ~samp;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with auto-incrementing register file; SCL/SDA are oversampled by clk.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_SLAVE_ADDR,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input logic               clk,
    input logic               rst,
    i2c_slave_regfile_if.slave bus
);
    localparam int               PTR_W    = $clog2(NUM_REGS);
    localparam logic [PTR_W:0]   REG_CNT  = NUM_REGS[PTR_W:0];
    localparam logic [PTR_W-1:0] LAST_REG = PTR_W'(NUM_REGS - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk, .rst, .raw(bus.scl_i), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk, .rst, .raw(bus.sda_i), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_t       state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shifter;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic             rw, mack, fall_d;
    logic             sda_oe, busy, rx_valid;
    logic [PTR_W-1:0] rx_addr;
    logic [7:0]       rx_data;
    logic [7:0]       regs [NUM_REGS];
    logic [7:0]       rd_cur, rd_nxt;

    assign ptr_nxt      = (ptr == LAST_REG) ? '0 : ptr + 1'b1;
    assign rd_cur       = regs[ptr];
    assign rd_nxt       = regs[ptr_nxt];
    assign bus.sda_oe   = sda_oe;
    assign bus.busy     = busy;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_addr  = rx_addr;
    assign bus.rx_data  = rx_data;

    // The I2C commit is applied after the host write so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (bus.host_wr_en && ({1'b0, bus.host_addr} < REG_CNT))
                regs[bus.host_addr] <= bus.host_wdata;
            if (rx_valid)
                regs[rx_addr] <= rx_data;
        end
    end

    // Bits are sampled on the filtered SCL rise; SDA is only ever changed one cycle
    // after the filtered SCL fall, well inside the low phase.
    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        fall_d   <= scl_fall;
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shifter <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            mack    <= I2C_NACK;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            fall_d  <= 1'b0;
            rx_addr <= '0;
            rx_data <= '0;
        end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, PTR, WR: begin
                    shifter <= {shifter[6:0], sda_lvl};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (state == WR && bit_cnt == 4'd7) begin
                        rx_valid <= 1'b1;
                        rx_addr  <= ptr;
                        rx_data  <= {shifter[6:0], sda_lvl};
                    end
                end
                RD:      bit_cnt <= bit_cnt + 4'd1;
                RD_ACK:  mack <= sda_lvl;
                default: ;
            endcase
        end else if (fall_d) begin
            case (state)
                ADDR: if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                    if (shifter[7:1] == SLAVE_ADDR) begin
                        state  <= ADDR_ACK;
                        sda_oe <= ~I2C_ACK;
                        busy   <= 1'b1;
                        rw     <= shifter[0];
                    end else begin
                        state <= WAIT_STOP;
                    end
                end
                ADDR_ACK: if (rw) begin
                    state   <= RD;
                    sda_oe  <= ~rd_cur[7];
                    shifter <= {rd_cur[6:0], 1'b0};
                end else begin
                    state  <= PTR;
                    sda_oe <= 1'b0;
                end
                PTR: if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                    if ({1'b0, shifter} >= 9'(NUM_REGS)) begin
                        state <= WAIT_STOP;
                    end else begin
                        ptr    <= shifter[PTR_W-1:0];
                        sda_oe <= ~I2C_ACK;
                        state  <= PTR_ACK;
                    end
                end
                PTR_ACK, WR_ACK: begin
                    sda_oe <= 1'b0;
                    state  <= WR;
                end
                WR: if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                    sda_oe  <= ~I2C_ACK;
                    ptr     <= ptr_nxt;
                    state   <= WR_ACK;
                end
                RD: if (bit_cnt == 4'd8) begin
                    bit_cnt <= '0;
                    sda_oe  <= 1'b0;
                    state   <= RD_ACK;
                end else begin
                    sda_oe  <= ~shifter[7];
                    shifter <= {shifter[6:0], 1'b0};
                end
                RD_ACK: if (mack == I2C_NACK) begin
                    state <= WAIT_STOP;
                end else begin
                    ptr     <= ptr_nxt;
                    sda_oe  <= ~rd_nxt[7];
                    shifter <= {rd_nxt[6:0], 1'b0};
                    state   <= RD;
                end
                default: ;
            endcase
        end
    end
endmodule
